// File: rtl/noc_run_ctrl.sv
// Run sequencer for the 3x3 NoC benches.
// Walks IDLE -> WARMUP -> INJECT -> DRAIN -> DONE, or FAIL on drain timeout / flit underflow,
// gates the shared injection enable and counts injected/ejected flits over all nodes.
//
// Ports:
//   clk        bench clock, all state changes on posedge
//   reset      synchronous active-high reset
//   start      level; starts a fresh run from IDLE, DONE or FAIL
//   abort      level; returns to IDLE from any state, counters kept for readout
//   inj_pulse  per-node "source injected one flit this cycle"
//   ej_pulse   per-node "sink accepted one flit this cycle"
//   send       injection enable to all sources (high only in INJECT)
//   phase      0 IDLE, 1 WARMUP, 2 INJECT, 3 DRAIN, 4 DONE, 5 FAIL
//   done/fail  state decodes
//   underflow  sticky: ejected count exceeded injected count
//   inj_count, ej_count, in_flight, run_cycles  run statistics
module noc_run_ctrl #(
  parameter int unsigned NODES         = 9,
  parameter int unsigned WARMUP        = 16,
  parameter int unsigned INJ_FLITS     = 1024,
  parameter int unsigned DRAIN_TIMEOUT = 4096,
  parameter int unsigned CNT_W         = 20
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic [NODES-1:0] inj_pulse,
  input  logic [NODES-1:0] ej_pulse,
  output logic             send,
  output logic [2:0]       phase,
  output logic             done,
  output logic             fail,
  output logic             underflow,
  output logic [CNT_W-1:0] inj_count,
  output logic [CNT_W-1:0] ej_count,
  output logic [CNT_W-1:0] in_flight,
  output logic [CNT_W-1:0] run_cycles
);

  localparam int unsigned PcW      = $clog2(NODES + 1);
  localparam int unsigned TimerMax = (DRAIN_TIMEOUT > WARMUP) ? DRAIN_TIMEOUT : WARMUP;
  localparam int unsigned TimerW   = $clog2(TimerMax + 1);

  // WarmLast is unused when WARMUP is 0 (WARMUP state is never entered).
  localparam logic [TimerW-1:0] WarmLast  = TimerW'(WARMUP - 1);
  localparam logic [TimerW-1:0] DrainLast = TimerW'(DRAIN_TIMEOUT - 1);
  localparam logic [CNT_W:0]    InjThresh = (CNT_W + 1)'(INJ_FLITS);

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StWarmup = 3'd1,
    StInject = 3'd2,
    StDrain  = 3'd3,
    StDone   = 3'd4,
    StFail   = 3'd5
  } state_e;

  state_e             state_q, state_d;
  logic               send_q, send_d;
  logic               underflow_q, underflow_d;
  logic [TimerW-1:0]  timer_q, timer_d;
  logic [CNT_W-1:0]   inj_q, inj_d, ej_q, ej_d, run_q, run_d;

  logic [PcW-1:0]     inj_pc, ej_pc;
  logic [CNT_W:0]     inj_sum, ej_sum, run_sum;
  logic [CNT_W-1:0]   inj_sat, ej_sat, run_sat;
  logic               restartable;

  function automatic logic [PcW-1:0] popcount(input logic [NODES-1:0] v);
    logic [PcW-1:0] c;
    c = '0;
    for (int i = 0; i < int'(NODES); i++) begin
      c = c + PcW'(v[i]);
    end
    return c;
  endfunction

  // Sums carry one extra bit so saturation is a simple check of the top bit.
  always_comb begin
    inj_pc  = popcount(inj_pulse);
    ej_pc   = popcount(ej_pulse);
    inj_sum = {1'b0, inj_q} + (CNT_W + 1)'(inj_pc);
    ej_sum  = {1'b0, ej_q} + (CNT_W + 1)'(ej_pc);
    run_sum = {1'b0, run_q} + (CNT_W + 1)'(1);
    inj_sat = inj_sum[CNT_W] ? {CNT_W{1'b1}} : inj_sum[CNT_W-1:0];
    ej_sat  = ej_sum[CNT_W] ? {CNT_W{1'b1}} : ej_sum[CNT_W-1:0];
    run_sat = run_sum[CNT_W] ? {CNT_W{1'b1}} : run_sum[CNT_W-1:0];
  end

  assign restartable = (state_q == StIdle) || (state_q == StDone) || (state_q == StFail);

  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q;
    inj_d       = inj_q;
    ej_d        = ej_q;
    run_d       = run_q;
    underflow_d = underflow_q;

    // Pulses are counted in every state except IDLE, including DONE and FAIL.
    if (state_q != StIdle) begin
      inj_d = inj_sat;
      ej_d  = ej_sat;
    end

    unique case (state_q)
      StWarmup: begin
        timer_d = timer_q + TimerW'(1);
        if (timer_q == WarmLast) begin
          state_d = StInject;
        end
      end
      StInject: begin
        run_d = run_sat;
        // Threshold uses this cycle's pulses so send drops one cycle after the crossing pulse.
        if (inj_sum >= InjThresh) begin
          state_d = StDrain;
          timer_d = '0;
        end
      end
      StDrain: begin
        run_d   = run_sat;
        timer_d = timer_q + TimerW'(1);
        if ((ej_sat == inj_sat) && (inj_pc == '0)) begin
          state_d = StDone;
        end else if (timer_q == DrainLast) begin
          state_d = StFail;
        end
      end
      StIdle, StDone, StFail: ;
      default: state_d = StIdle;
    endcase

    // Counts are frozen in IDLE, so a stale ej > inj kept after an abort must not re-trip FAIL.
    if ((state_q != StIdle) && (ej_sat > inj_sat)) begin
      underflow_d = 1'b1;
      state_d     = StFail;
    end

    if (start && restartable) begin
      inj_d       = '0;
      ej_d        = '0;
      run_d       = '0;
      underflow_d = 1'b0;
      timer_d     = '0;
      state_d     = (WARMUP == 0) ? StInject : StWarmup;
    end

    // Abort keeps the registered counters and flag untouched for readout.
    if (abort) begin
      state_d     = StIdle;
      timer_d     = '0;
      inj_d       = inj_q;
      ej_d        = ej_q;
      run_d       = run_q;
      underflow_d = underflow_q;
    end

    send_d = (state_d == StInject);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      send_q      <= 1'b0;
      underflow_q <= 1'b0;
      timer_q     <= '0;
      inj_q       <= '0;
      ej_q        <= '0;
      run_q       <= '0;
    end else begin
      state_q     <= state_d;
      send_q      <= send_d;
      underflow_q <= underflow_d;
      timer_q     <= timer_d;
      inj_q       <= inj_d;
      ej_q        <= ej_d;
      run_q       <= run_d;
    end
  end

  assign send       = send_q;
  assign phase      = state_q;
  assign done       = (state_q == StDone);
  assign fail       = (state_q == StFail);
  assign underflow  = underflow_q;
  assign inj_count  = inj_q;
  assign ej_count   = ej_q;
  assign in_flight  = (inj_q > ej_q) ? (inj_q - ej_q) : '0;
  assign run_cycles = run_q;

endmodule

// File: tb/tb_noc_run_ctrl.sv
// Bench for noc_run_ctrl: directed run scenarios, a behavioural run model compared every cycle,
// plus literal expectations at the key points of each scenario.
module tb_noc_run_ctrl;

  localparam int NODES_P = 9;
  localparam int WARM    = 16;
  localparam int INJF    = 20;
  localparam int DTO     = 8;
  localparam int CW      = 20;
  localparam int MAXC    = (1 << CW) - 1;

  localparam int PH_IDLE  = 0;
  localparam int PH_WARM  = 1;
  localparam int PH_INJ   = 2;
  localparam int PH_DRAIN = 3;
  localparam int PH_DONE  = 4;
  localparam int PH_FAIL  = 5;

  logic               clk = 1'b0;
  logic               reset, start, abort;
  logic [NODES_P-1:0] inj_pulse, ej_pulse;
  logic               send, done, fail, underflow;
  logic [2:0]         phase;
  logic [CW-1:0]      inj_count, ej_count, in_flight, run_cycles;

  int checks = 0;
  int errors = 0;

  // Model of the run: phase, counts and cycles spent in the current timed phase.
  int m_ph, m_inj, m_ej, m_run, m_tmr, m_under;

  noc_run_ctrl #(
    .NODES        (NODES_P),
    .WARMUP       (WARM),
    .INJ_FLITS    (INJF),
    .DRAIN_TIMEOUT(DTO),
    .CNT_W        (CW)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .abort     (abort),
    .inj_pulse (inj_pulse),
    .ej_pulse  (ej_pulse),
    .send      (send),
    .phase     (phase),
    .done      (done),
    .fail      (fail),
    .underflow (underflow),
    .inj_count (inj_count),
    .ej_count  (ej_count),
    .in_flight (in_flight),
    .run_cycles(run_cycles)
  );

  always #5 clk = ~clk;

  function automatic int sat(input int x);
    return (x > MAXC) ? MAXC : x;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_step();
    int ip, ep, ni, ne, nph;
    ip = $countones(inj_pulse);
    ep = $countones(ej_pulse);
    if (reset) begin
      m_ph = PH_IDLE; m_inj = 0; m_ej = 0; m_run = 0; m_tmr = 0; m_under = 0;
      return;
    end
    if (abort) begin
      m_ph = PH_IDLE;
      return;
    end
    if (start && (m_ph == PH_IDLE || m_ph == PH_DONE || m_ph == PH_FAIL)) begin
      m_inj = 0; m_ej = 0; m_run = 0; m_under = 0; m_tmr = 0;
      m_ph = (WARM == 0) ? PH_INJ : PH_WARM;
      return;
    end
    if (m_ph == PH_IDLE) return;
    ni  = sat(m_inj + ip);
    ne  = sat(m_ej + ep);
    nph = m_ph;
    case (m_ph)
      PH_WARM: begin
        m_tmr++;
        if (m_tmr == WARM) nph = PH_INJ;
      end
      PH_INJ: begin
        m_run = sat(m_run + 1);
        if (m_inj + ip >= INJF) begin
          nph   = PH_DRAIN;
          m_tmr = 0;
        end
      end
      PH_DRAIN: begin
        m_run = sat(m_run + 1);
        m_tmr++;
        if (ne == ni && ip == 0) nph = PH_DONE;
        else if (m_tmr == DTO) nph = PH_FAIL;
      end
      default: ;
    endcase
    if (ne > ni) begin
      m_under = 1;
      nph     = PH_FAIL;
    end
    m_inj = ni;
    m_ej  = ne;
    m_ph  = nph;
  endtask

  task automatic compare_model();
    chk("phase", int'(phase), m_ph);
    chk("send", int'(send), int'(m_ph == PH_INJ));
    chk("done", int'(done), int'(m_ph == PH_DONE));
    chk("fail", int'(fail), int'(m_ph == PH_FAIL));
    chk("underflow", int'(underflow), m_under);
    chk("inj_count", int'(inj_count), m_inj);
    chk("ej_count", int'(ej_count), m_ej);
    chk("in_flight", int'(in_flight), (m_inj > m_ej) ? m_inj - m_ej : 0);
    chk("run_cycles", int'(run_cycles), m_run);
  endtask

  // One clock: DUT and model both advance on the posedge, outputs compared on the negedge.
  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare_model();
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  logic [NODES_P-1:0] ej_t3 [5];
  logic [NODES_P-1:0] ej_t4 [8];
  int                 fl_t3 [5];

  initial begin
    ej_t3 = '{9'h1FF, 9'h1FF, 9'h00F, 9'h0F0, 9'h100};
    fl_t3 = '{18, 9, 5, 1, 0};
    ej_t4 = '{9'h1FF, 9'h1FF, 9'h0FF, 9'h000, 9'h000, 9'h000, 9'h000, 9'h000};
    m_ph = 0; m_inj = 0; m_ej = 0; m_run = 0; m_tmr = 0; m_under = 0;

    reset = 1'b1; start = 1'b0; abort = 1'b0; inj_pulse = '0; ej_pulse = '0;
    ticks(2);
    chk("reset phase", int'(phase), 0);
    chk("reset send", int'(send), 0);
    chk("reset inj", int'(inj_count), 0);
    reset = 1'b0;
    tick();

    // 1: start -> 16 WARMUP cycles, send rises 17 cycles after start
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("t1 warmup entry", int'(phase), 1);
    ticks(15);
    chk("t1 last warmup", int'(phase), 1);
    chk("t1 send low", int'(send), 0);
    tick();
    chk("t1 inject phase", int'(phase), 2);
    chk("t1 send high", int'(send), 1);
    chk("t1 inj zero", int'(inj_count), 0);

    // 2: three full-width injection cycles cross INJ_FLITS=20 with overshoot to 27
    inj_pulse = 9'h1FF;
    tick();
    chk("t2 inj 9", int'(inj_count), 9);
    tick();
    chk("t2 inj 18", int'(inj_count), 18);
    chk("t2 still inject", int'(phase), 2);
    tick();
    inj_pulse = '0;
    chk("t2 inj 27", int'(inj_count), 27);
    chk("t2 drain", int'(phase), 3);
    chk("t2 send low", int'(send), 0);

    // 3: eject 27 over 5 cycles -> DONE, run_cycles frozen at 3 inject + 5 drain
    for (int i = 0; i < 5; i++) begin
      ej_pulse = ej_t3[i];
      tick();
      chk("t3 in_flight", int'(in_flight), fl_t3[i]);
    end
    ej_pulse = '0;
    chk("t3 done", int'(done), 1);
    chk("t3 phase", int'(phase), 4);
    ticks(2);
    chk("t3 run frozen", int'(run_cycles), 8);
    inj_pulse = 9'h001;
    tick();
    inj_pulse = '0;
    chk("t3 late inj", int'(inj_count), 28);
    chk("t3 stays done", int'(phase), 4);
    ej_pulse = 9'h001;
    tick();
    ej_pulse = '0;
    chk("t3 late ej", int'(ej_count), 28);

    // 4: restart from DONE, drain with ej stuck at inj-1 -> FAIL after 8 drain cycles
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("t4 cleared inj", int'(inj_count), 0);
    chk("t4 warmup", int'(phase), 1);
    ticks(16);
    inj_pulse = 9'h1FF;
    ticks(3);
    inj_pulse = '0;
    for (int i = 0; i < 8; i++) begin
      ej_pulse = ej_t4[i];
      tick();
      if (i == 6) chk("t4 drain at 7", int'(phase), 3);
    end
    ej_pulse = '0;
    chk("t4 fail", int'(fail), 1);
    chk("t4 fail phase", int'(phase), 5);
    chk("t4 ej stuck", int'(ej_count), 26);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("t4 restart phase", int'(phase), 1);
    chk("t4 restart ej", int'(ej_count), 0);

    // 5: ejection with nothing injected -> underflow and FAIL, abort keeps the flag
    ticks(16);
    ej_pulse = 9'h003;
    tick();
    ej_pulse = '0;
    chk("t5 underflow", int'(underflow), 1);
    chk("t5 fail phase", int'(phase), 5);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("t5 abort idle", int'(phase), 0);
    chk("t5 underflow kept", int'(underflow), 1);
    chk("t5 ej kept", int'(ej_count), 2);
    tick();
    chk("t5 idle holds", int'(phase), 0);

    // 6: reset mid-INJECT with start asserted -> everything cleared
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("t6 underflow cleared", int'(underflow), 0);
    ticks(16);
    inj_pulse = 9'h00F;
    tick();
    chk("t6 inj 4", int'(inj_count), 4);
    chk("t6 send", int'(send), 1);
    reset = 1'b1;
    start = 1'b1;
    tick();
    reset = 1'b0;
    start = 1'b0;
    inj_pulse = '0;
    chk("t6 phase", int'(phase), 0);
    chk("t6 send", int'(send), 0);
    chk("t6 inj", int'(inj_count), 0);
    chk("t6 run", int'(run_cycles), 0);
    chk("t6 underflow", int'(underflow), 0);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
